// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: command bytes, load terminator,
// default widths and FSM state encodings.
package program_loader_pkg;

    localparam int          PC_BITS_DEF          = 11;
    localparam int          INSTRUCTION_BITS_DEF = 32;
    localparam logic [31:0] HALT_WORD_DEF        = 32'hFFFF_FFFF;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_STEP  = 8'h03;
    localparam logic [7:0] CMD_ABORT = 8'h04;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_STEP = 2'd3;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; o_word_valid pulses the
// cycle after the 4th byte while o_word still holds the completed word.
module program_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [31:0] r_shift;
    logic [1:0]  r_count;
    logic        r_word_valid;

    // A byte accepted during the valid cycle shifts in at the closing edge,
    // so the completed word is still intact for the whole valid cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                r_shift <= {r_shift[23:0], i_byte};
                r_count <= r_count + 2'd1;
                if (r_count == 2'd3) begin
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_shift;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/program_loader.sv
// Command FSM in front of the Datapath: loads instruction memory from UART
// bytes, then sequences run / single-step / abort via enable and reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          PC_BITS          = PC_BITS_DEF,
    parameter int          INSTRUCTION_BITS = INSTRUCTION_BITS_DEF,
    parameter logic [31:0] HALT_WORD        = HALT_WORD_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_valid,
    input  logic                        i_halt,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_enable,
    output logic                        o_dp_rst,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error
);

    localparam logic [PC_BITS-1:0] ADDR_LAST = '1;

    state_t               r_state;
    logic [PC_BITS-1:0]   r_addr;
    logic                 r_enable;
    logic                 r_dp_rst;
    logic                 r_done;
    logic                 r_error;

    logic                 w_cmd_load;
    logic                 w_asm_valid;
    logic [31:0]          w_word;
    logic                 w_word_valid;
    logic                 w_write;

    assign w_cmd_load  = (r_state == ST_IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);
    assign w_asm_valid = (r_state == ST_LOAD) && i_rx_valid;
    assign w_write     = (r_state == ST_LOAD) && w_word_valid;

    program_loader_word_assembler u_word_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_cmd_load),
        .i_byte       (i_rx_data),
        .i_byte_valid (w_asm_valid),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_enable <= 1'b0;
            r_dp_rst <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_state  <= ST_LOAD;
                                r_addr   <= '0;
                                r_dp_rst <= 1'b1;
                                r_error  <= 1'b0;
                            end
                            // r_dp_rst high means no complete program is in memory.
                            CMD_RUN: begin
                                if (r_dp_rst) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_state  <= ST_RUN;
                                    r_enable <= !i_halt;
                                end
                            end
                            CMD_STEP: begin
                                if (r_dp_rst) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_state  <= ST_STEP;
                                    r_enable <= 1'b1;
                                end
                            end
                            default: r_error <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (w_write) begin
                        if (w_word == HALT_WORD) begin
                            r_state  <= ST_IDLE;
                            r_done   <= 1'b1;
                            r_dp_rst <= 1'b0;
                        end else if (r_addr == ADDR_LAST) begin
                            r_state <= ST_IDLE;
                            r_error <= 1'b1;
                        end else begin
                            r_addr <= r_addr + PC_BITS'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        r_enable <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (i_rx_valid && (i_rx_data == CMD_ABORT)) begin
                        r_enable <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    r_enable <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_write_inst_mem = w_write;
    assign o_inst_mem_addr  = r_addr;
    assign o_inst_mem_data  = w_word;
    assign o_enable         = r_enable;
    assign o_dp_rst         = r_dp_rst;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = r_done;
    assign o_error          = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: byte-level drivers, a word/address
// scoreboard built from the program image, and enable/done cycle counters.
module tb_program_loader;

    localparam int          PC_BITS = 11;
    localparam int          DEPTH   = 1 << PC_BITS;
    localparam int          W       = PC_BITS + 32;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         i_rx_data = 8'h00;
    logic               i_rx_valid = 1'b0;
    logic               i_halt = 1'b0;
    logic               o_write_inst_mem;
    logic [PC_BITS-1:0] o_inst_mem_addr;
    logic [31:0]        o_inst_mem_data;
    logic               o_enable;
    logic               o_dp_rst;
    logic               o_busy;
    logic               o_done;
    logic               o_error;

    program_loader #(.PC_BITS(PC_BITS)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_rx_data        (i_rx_data),
        .i_rx_valid       (i_rx_valid),
        .i_halt           (i_halt),
        .o_write_inst_mem (o_write_inst_mem),
        .o_inst_mem_addr  (o_inst_mem_addr),
        .o_inst_mem_data  (o_inst_mem_data),
        .o_enable         (o_enable),
        .o_dp_rst         (o_dp_rst),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_error          (o_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];
    logic [31:0]   prog_q[$];
    int            n_total = 0;
    int            n_bad = 0;
    int            en_cnt = 0;
    int            done_cnt = 0;
    int            last_en_cyc = 0;
    int            done_cyc = 0;
    int            last_wr_cyc = 0;
    bit            m_loaded = 1'b0;
    bit            m_error = 1'b0;

    always @(negedge clk) begin
        if (o_write_inst_mem) begin
            got_q.push_back({o_inst_mem_addr, o_inst_mem_data});
            last_wr_cyc = cyc;
        end
        if (o_enable) begin
            en_cnt++;
            last_en_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        en_cnt = 0;
        done_cnt = 0;
        last_en_cyc = -100;
        done_cyc = -100;
        last_wr_cyc = -100;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_rx_valid = 1'b0;
        i_halt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_loaded = 1'b0;
        m_error = 1'b0;
        clear_counters();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) check(tag, 64'(o_busy), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_err"}, 64'(o_error), 64'(m_error));
        check({tag, "_dprst"}, 64'(o_dp_rst), 64'(!m_loaded));
        check({tag, "_en"}, 64'(o_enable), 64'(0));
    endtask

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h04);
        return b;
    endfunction

    // Expected writes: word i of the image lands at address i; the image ends
    // at the first HALT word or, lacking one, at the last address with an error.
    task automatic load_program(input string tag, input bit gaps);
        bit hit_halt = 1'b0;
        bit hit_wrap = 1'b0;
        clear_counters();
        send_byte(8'h01);
        m_error = 1'b0;
        m_loaded = 1'b0;
        check({tag, "_errclr"}, 64'(o_error), 64'(0));
        check({tag, "_dprst_on"}, 64'(o_dp_rst), 64'(1));
        foreach (prog_q[i]) begin
            exp_q.push_back({PC_BITS'(i), prog_q[i]});
            for (int b = 3; b >= 0; b--) begin
                send_byte(prog_q[i][8*b +: 8]);
                if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            end
            if (prog_q[i] == HALT) begin
                hit_halt = 1'b1;
                break;
            end
            if (i == DEPTH - 1) begin
                hit_wrap = 1'b1;
                break;
            end
        end
        wait_idle({tag, "_timeout"}, 50);
        m_loaded = hit_halt;
        m_error = hit_wrap;
        check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_wr"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(hit_halt));
        if (hit_halt) check({tag, "_done_lag"}, 64'(done_cyc - last_wr_cyc), 64'(1));
        check_status(tag);
    endtask

    task automatic make_prog(input int n);
        logic [31:0] w;
        prog_q.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            prog_q.push_back(w);
        end
    endtask

    task automatic run_test(input string tag, input int k, input bit halt_on_entry);
        int exp_en;
        clear_counters();
        exp_en = halt_on_entry ? 0 : k;
        if (halt_on_entry) i_halt = 1'b1;
        send_byte(8'h02);
        if (!halt_on_entry) begin
            for (int j = 1; j < k; j++) begin
                if ($urandom_range(0, 2) == 0) send_byte(noise_byte());
                else tick();
            end
            i_halt = 1'b1;
        end
        wait_idle({tag, "_timeout"}, 50);
        i_halt = 1'b0;
        check({tag, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        if (exp_en > 0) check({tag, "_done_at_fall"}, 64'(done_cyc - last_en_cyc), 64'(1));
        check_status(tag);
    endtask

    task automatic step_test(input string tag);
        clear_counters();
        i_halt = 1'($urandom_range(0, 1));
        send_byte(8'h03);
        wait_idle({tag, "_timeout"}, 20);
        i_halt = 1'b0;
        check({tag, "_en_cycles"}, 64'(en_cnt), 64'(1));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        check({tag, "_done_at_fall"}, 64'(done_cyc - last_en_cyc), 64'(1));
        check_status(tag);
    endtask

    task automatic abort_test(input string tag, input int j);
        clear_counters();
        send_byte(8'h02);
        for (int n = 0; n < j; n++) begin
            if ($urandom_range(0, 1) == 0) send_byte(noise_byte());
            else tick();
        end
        send_byte(8'h04);
        wait_idle({tag, "_timeout"}, 20);
        tick();
        check({tag, "_en_cycles"}, 64'(en_cnt), 64'(j + 1));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(0));
        check_status(tag);
    endtask

    task automatic bad_cmd_test(input string tag, input logic [7:0] b);
        clear_counters();
        send_byte(b);
        m_error = 1'b1;
        tick();
        tick();
        check({tag, "_en_cnt"}, 64'(en_cnt), 64'(0));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(0));
        check_status(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        int         n;

        do_reset();
        check("rst_write", 64'(o_write_inst_mem), 64'(0));
        check("rst_addr", 64'(o_inst_mem_addr), 64'(0));
        check("rst_data", 64'(o_inst_mem_data), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check_status("rst");

        bad_cmd_test("guard_run", 8'h02);
        bad_cmd_test("guard_step", 8'h03);

        prog_q = '{32'h2008_0005, HALT};
        load_program("load_plan", 1'b0);

        run_test("run_k7", 7, 1'b0);
        for (int r = 0; r < 3; r++) run_test("run_rand", $urandom_range(1, 20), 1'b0);
        run_test("run_halted", 1, 1'b1);

        for (int r = 0; r < 3; r++) step_test("step");

        abort_test("abort_3", 3);
        abort_test("abort_rand", $urandom_range(0, 10));
        bad_cmd_test("bad_55", 8'h55);
        do b = 8'($urandom); while (b >= 8'h01 && b <= 8'h03);
        bad_cmd_test("bad_rand", b);

        for (int r = 0; r < 3; r++) begin
            make_prog($urandom_range(0, 20));
            prog_q.push_back(HALT);
            load_program("load_rand", 1'b1);
            run_test("run_after", $urandom_range(1, 12), 1'b0);
        end

        // Partial load (one full word plus a fragment) aborted by reset.
        clear_counters();
        send_byte(8'h01);
        n = $urandom_range(5, 7);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
        do_reset();
        check_status("mid_load_rst");
        prog_q = '{HALT};
        load_program("load_after_rst", 1'b0);

        // Reset while running.
        send_byte(8'h02);
        tick();
        tick();
        do_reset();
        check_status("mid_run_rst");
        bad_cmd_test("guard_after_rst", 8'h02);

        make_prog(DEPTH);
        load_program("load_wrap", 1'b0);
        bad_cmd_test("guard_after_wrap", 8'h03);

        make_prog(DEPTH - 1);
        prog_q.push_back(HALT);
        load_program("load_full", 1'b0);
        step_test("step_full");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
